// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package cache_pkg;

    // Controller states: idle lookup, read refill, write-through, load response.
    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        RESP
    } cache_state_t;

    // Line layout: one word per line, so only the byte offset sits below the index.
    localparam int OFS_W   = 2;
    localparam int VALID_W = 1;

    // Number of index bits for a given line count.
    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over after index and byte offset.
    function automatic int tag_width(input int aw, input int sets);
        return aw - index_width(sets) - OFS_W;
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Cache-to-main-memory request/acknowledge bus.
interface dcache_ctrl_if #(
    parameter int WD = 32,
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WD-1:0] mem_wdata;
    logic          mem_ack;
    logic [WD-1:0] mem_rdata_in;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata_in
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata_in
    );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one synchronous write port, one asynchronous read port.
module dcache_array
    import cache_pkg::*;
#(
    parameter int WD   = 32,
    parameter int AW   = 32,
    parameter int SETS = 64,
    localparam int IW  = index_width(SETS),
    localparam int TW  = tag_width(AW, SETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [WD-1:0] rd_data,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic [WD-1:0] wr_data
);

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [WD-1:0]   data_q [SETS];

    // Valid bits: cleared on reset, set whenever a line is written.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload written alongside the valid bit.
    // NOTE: payload arrays have no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, one-word-line data cache controller.
// Optional: define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int WD   = 32,
    parameter int AW   = 32,
    parameter int SETS = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [WD-1:0] wr_data,
    output logic          hit,
    output logic [WD-1:0] cache_rdata,
    output logic [WD-1:0] mem_rdata,
    output logic          stall,
    dcache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam int IW = index_width(SETS);
    localparam int TW = tag_width(AW, SETS);

    cache_state_t  state, next_state;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic          tag_hit;
    logic          arr_we;
    logic [WD-1:0] arr_wdata;
    logic          unused_ofs;

    assign index      = addr[IW+1:2];
    assign tag        = addr[AW-1:IW+2];
    assign unused_ofs = ^addr[1:0];

    dcache_array #(.WD(WD), .AW(AW), .SETS(SETS)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (cache_rdata),
        .we       (arr_we),
        .wr_idx   (index),
        .wr_tag   (tag),
        .wr_data  (arr_wdata)
    );

    assign tag_hit = line_valid && (line_tag == tag);
    assign hit     = tag_hit && rd_en && (state == IDLE);

    // Request fields follow the stalled address/data, so they stay stable until ack.
    assign mem.mem_addr  = {addr[AW-1:2], 2'b00};
    assign mem.mem_wdata = wr_data;
    assign arr_wdata     = (state == RD_MISS) ? mem.mem_rdata_in : wr_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state, stall, memory handshake and array write enable.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        next_state  = state;
        stall       = 1'b0;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        arr_we      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_en && !tag_hit) begin
                    stall      = 1'b1;
                    next_state = RD_MISS;
                end else if (wr_en) begin
                    stall      = 1'b1;
                    next_state = WR_THRU;
                end
            end
            RD_MISS: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    arr_we     = 1'b1;
                    next_state = RESP;
                end
            end
            WR_THRU: begin
                stall       = !mem.mem_ack;
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                if (mem.mem_ack) begin
                    arr_we     = tag_hit;
                    next_state = IDLE;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the refill word for the select stage's RESP cycle.
    always_ff @(posedge clk) begin
        if (rst)                              mem_rdata <= '0;
        else if (state == RD_MISS && mem.mem_ack) mem_rdata <= mem.mem_rdata_in;
    end

`ifdef DCACHE_STATS_EN
    // Saturating counters of idle read hits and of read misses entering refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && next_state == RD_MISS && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (SETS=64, so 0x100/0x200 share index 0).
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        hit;
    logic [31:0] cache_rdata;
    logic [31:0] mem_rdata;
    logic        stall;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dcache_ctrl_if #(.WD(32), .AW(32)) mem_bus ();

    dcache_ctrl #(.WD(32), .AW(32), .SETS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .hit         (hit),
        .cache_rdata (cache_rdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .mem         (mem_bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Observations recorded by the stimulus helpers, compared by the test tasks.
    int          obs_stalls;
    logic        obs_idle_hit;
    logic        obs_req, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic        obs_resp_hit, obs_resp_stall;
    logic [31:0] obs_resp_rdata;
    logic        obs_rl_hit, obs_rl_stall;
    logic [31:0] obs_rl_data;
    logic        obs_w_pre_stall, obs_w_ack_stall, obs_w_after_req;
    logic        obs_p_hit, obs_p_stall;
    logic [31:0] obs_p_data;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Load that misses: memory acks in the dly-th request cycle, then RESP and a re-lookup.
    task automatic read_miss(input logic [31:0] a, input logic [31:0] d, input int dly);
        obs_stalls = 0;
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        #1;
        obs_idle_hit = hit;
        if (stall) obs_stalls++;
        for (int k = 1; k <= dly; k++) begin
            tick;
            if (k == dly) begin
                mem_bus.mem_ack      = 1'b1;
                mem_bus.mem_rdata_in = d;
            end
            #1;
            if (stall) obs_stalls++;
            if (k == dly) begin
                obs_req  = mem_bus.mem_req;
                obs_we   = mem_bus.mem_we;
                obs_addr = mem_bus.mem_addr;
            end
        end
        tick;
        mem_bus.mem_ack      = 1'b0;
        mem_bus.mem_rdata_in = '0;
        #1;
        obs_resp_hit   = hit;
        obs_resp_stall = stall;
        obs_resp_rdata = mem_rdata;
        tick;
        #1;
        obs_rl_hit   = hit;
        obs_rl_data  = cache_rdata;
        obs_rl_stall = stall;
        tick;
        rd_en = 1'b0;
        #1;
    endtask

    // Store through to memory, ack in the dly-th request cycle.
    task automatic write_thru(input logic [31:0] a, input logic [31:0] d, input int dly);
        addr = a; wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
        #1;
        obs_w_pre_stall = stall;
        for (int k = 1; k <= dly; k++) begin
            tick;
            if (k == dly) mem_bus.mem_ack = 1'b1;
            #1;
            if (k < dly) begin
                obs_w_pre_stall = obs_w_pre_stall & stall;
            end else begin
                obs_w_ack_stall = stall;
                obs_req   = mem_bus.mem_req;
                obs_we    = mem_bus.mem_we;
                obs_addr  = mem_bus.mem_addr;
                obs_wdata = mem_bus.mem_wdata;
            end
        end
        tick;
        mem_bus.mem_ack = 1'b0;
        wr_en = 1'b0;
        #1;
        obs_w_after_req = mem_bus.mem_req;
    endtask

    // Single-cycle load expected to hit.
    task automatic probe_read(input logic [31:0] a);
        addr = a; rd_en = 1'b1; wr_en = 1'b0;
        #1;
        obs_p_hit   = hit;
        obs_p_data  = cache_rdata;
        obs_p_stall = stall;
        tick;
        rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; addr = 32'h100; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata_in = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        total++; if (hit !== 1'b0)   begin bad++; $display("FAIL reset_hit got=%b want=0", hit); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_bus.mem_req); end
        total++; if (mem_bus.mem_we !== 1'b0)  begin bad++; $display("FAIL reset_we got=%b want=0", mem_bus.mem_we); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_mem_rdata got=%h want=0", mem_rdata); end
    endtask

    task automatic test_cold_miss;
        read_miss(32'h100, 32'hDEAD_BEEF, 3);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL cold_hit got=%b want=0", obs_idle_hit); end
        total++; if (obs_stalls != 4) begin bad++; $display("FAIL cold_stall_cycles got=%0d want=4", obs_stalls); end
        total++; if (obs_req !== 1'b1) begin bad++; $display("FAIL cold_req got=%b want=1", obs_req); end
        total++; if (obs_we !== 1'b0)  begin bad++; $display("FAIL cold_we got=%b want=0", obs_we); end
        total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL cold_addr got=%h want=100", obs_addr); end
        total++; if (obs_resp_hit !== 1'b0) begin bad++; $display("FAIL resp_hit got=%b want=0", obs_resp_hit); end
        total++; if (obs_resp_stall !== 1'b0) begin bad++; $display("FAIL resp_stall got=%b want=0", obs_resp_stall); end
        total++; if (obs_resp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL resp_rdata got=%h want=deadbeef", obs_resp_rdata); end
        total++; if (obs_rl_hit !== 1'b1) begin bad++; $display("FAIL relookup_hit got=%b want=1", obs_rl_hit); end
        total++; if (obs_rl_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL relookup_data got=%h want=deadbeef", obs_rl_data); end
        total++; if (obs_rl_stall !== 1'b0) begin bad++; $display("FAIL relookup_stall got=%b want=0", obs_rl_stall); end
    endtask

    task automatic test_write_hit;
        write_thru(32'h100, 32'h1234_5678, 2);
        total++; if (obs_w_pre_stall !== 1'b1) begin bad++; $display("FAIL wh_pre_stall got=%b want=1", obs_w_pre_stall); end
        total++; if (obs_w_ack_stall !== 1'b0) begin bad++; $display("FAIL wh_ack_stall got=%b want=0", obs_w_ack_stall); end
        total++; if (obs_req !== 1'b1) begin bad++; $display("FAIL wh_req got=%b want=1", obs_req); end
        total++; if (obs_we !== 1'b1)  begin bad++; $display("FAIL wh_we got=%b want=1", obs_we); end
        total++; if (obs_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wh_wdata got=%h want=12345678", obs_wdata); end
        total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL wh_addr got=%h want=100", obs_addr); end
        total++; if (obs_w_after_req !== 1'b0) begin bad++; $display("FAIL wh_after_req got=%b want=0", obs_w_after_req); end
        probe_read(32'h100);
        total++; if (obs_p_hit !== 1'b1) begin bad++; $display("FAIL wh_read_hit got=%b want=1", obs_p_hit); end
        total++; if (obs_p_data !== 32'h1234_5678) begin bad++; $display("FAIL wh_read_data got=%h want=12345678", obs_p_data); end
        total++; if (obs_p_stall !== 1'b0) begin bad++; $display("FAIL wh_read_stall got=%b want=0", obs_p_stall); end
    endtask

    task automatic test_write_miss;
        write_thru(32'h200, 32'hCAFE_F00D, 2);
        total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL wm_we got=%b want=1", obs_we); end
        total++; if (obs_addr !== 32'h200) begin bad++; $display("FAIL wm_addr got=%h want=200", obs_addr); end
        total++; if (obs_w_ack_stall !== 1'b0) begin bad++; $display("FAIL wm_ack_stall got=%b want=0", obs_w_ack_stall); end
        probe_read(32'h100);
        total++; if (obs_p_hit !== 1'b1) begin bad++; $display("FAIL wm_line_kept_hit got=%b want=1", obs_p_hit); end
        total++; if (obs_p_data !== 32'h1234_5678) begin bad++; $display("FAIL wm_line_kept_data got=%h want=12345678", obs_p_data); end
        read_miss(32'h200, 32'hCAFE_F00D, 1);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL wm_no_alloc got=%b want=0", obs_idle_hit); end
        total++; if (obs_stalls != 2) begin bad++; $display("FAIL wm_stall_cycles got=%0d want=2", obs_stalls); end
        total++; if (obs_rl_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL wm_fill_data got=%h want=cafef00d", obs_rl_data); end
    endtask

    task automatic test_conflict;
        read_miss(32'h100, 32'h1111_1111, 2);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL cf_first got=%b want=0", obs_idle_hit); end
        read_miss(32'h200, 32'h2222_2222, 2);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL cf_second got=%b want=0", obs_idle_hit); end
        total++; if (obs_rl_data !== 32'h2222_2222) begin bad++; $display("FAIL cf_second_data got=%h want=22222222", obs_rl_data); end
        read_miss(32'h100, 32'h3333_3333, 2);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL cf_third got=%b want=0", obs_idle_hit); end
        total++; if (obs_rl_hit !== 1'b1) begin bad++; $display("FAIL cf_refill_hit got=%b want=1", obs_rl_hit); end
        total++; if (obs_rl_data !== 32'h3333_3333) begin bad++; $display("FAIL cf_refill_data got=%h want=33333333", obs_rl_data); end
    endtask

    task automatic test_index_wrap;
        read_miss(32'h0000_00FF, 32'hA5A5_A5A5, 2);
        total++; if (obs_addr !== 32'h0000_00FC) begin bad++; $display("FAIL wrap_aligned_addr got=%h want=fc", obs_addr); end
        total++; if (obs_rl_hit !== 1'b1) begin bad++; $display("FAIL wrap_hit got=%b want=1", obs_rl_hit); end
        total++; if (obs_rl_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrap_data got=%h want=a5a5a5a5", obs_rl_data); end
        probe_read(32'h100);
        total++; if (obs_p_data !== 32'h3333_3333 || obs_p_hit !== 1'b1) begin
            bad++; $display("FAIL wrap_idx0_kept got=%b/%h want=1/33333333", obs_p_hit, obs_p_data);
        end
    endtask

    task automatic test_reset_mid_miss;
        addr = 32'h104; rd_en = 1'b1; wr_en = 1'b0;
        tick;
        #1;
        total++; if (mem_bus.mem_req !== 1'b1) begin bad++; $display("FAIL rm_in_miss got=%b want=1", mem_bus.mem_req); end
        rst = 1'b1;
        tick;
        rst = 1'b0; rd_en = 1'b0;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata_in = 32'hBAD0_BAD0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b want=0", stall); end
        total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b want=0", mem_bus.mem_req); end
        tick;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata_in = '0;
        #1;
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL rm_late_ack got=%h want=0", mem_rdata); end
        read_miss(32'h104, 32'h5555_AAAA, 1);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL rm_same_addr got=%b want=0", obs_idle_hit); end
        total++; if (obs_rl_data !== 32'h5555_AAAA) begin bad++; $display("FAIL rm_refill got=%h want=5555aaaa", obs_rl_data); end
        read_miss(32'h0000_00FC, 32'h0000_0001, 1);
        total++; if (obs_idle_hit !== 1'b0) begin bad++; $display("FAIL rm_valid_cleared got=%b want=0", obs_idle_hit); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        total++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", hit_cnt, miss_cnt);
        end
        read_miss(32'h40, 32'h0F0F_0F0F, 1);
        probe_read(32'h40);
        probe_read(32'h40);
        total++; if (miss_cnt !== 32'd1) begin bad++; $display("FAIL stats_miss got=%0d want=1", miss_cnt); end
        total++; if (hit_cnt !== 32'd3)  begin bad++; $display("FAIL stats_hit got=%0d want=3", hit_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_cold_miss;
        test_write_hit;
        test_write_miss;
        test_conflict;
        test_index_wrap;
        test_reset_mid_miss;
`ifdef DCACHE_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
